// File: rtl/jtag_debug_sys_pio_pkg.sv
// Shared constants and helpers for the debug-system input PIO.
package jtag_debug_sys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // Single-bit edge detector selected by capture type.
  function automatic logic edge_detect(input logic cur, input logic prev,
                                       input int unsigned etype);
    if (etype == EDGE_FALLING) return ~cur & prev;
    else if (etype == EDGE_ANY) return cur ^ prev;
    else return cur & ~prev;
  endfunction

endpackage

// File: rtl/jtag_debug_sys_pio_debounce.sv
// Per-bit stability filter; only built when JTAG_DEBUG_SYS_PIO_DEBOUNCE_EN is defined.
`ifdef JTAG_DEBUG_SYS_PIO_DEBOUNCE_EN
module jtag_debug_sys_pio_debounce #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0]  cnt_q [DATA_W];
  logic [CNT_W-1:0]  cnt_d [DATA_W];
  logic [DATA_W-1:0] f_q;
  logic [DATA_W-1:0] f_d;

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_comb begin
    f_d = f_q;
    for (int i = 0; i < DATA_W; i++) begin
      cnt_d[i] = '0;
      if (d[i] != f_q[i]) begin
        if (32'(cnt_q[i]) >= CYCLES - 1) f_d[i] = d[i];
        else cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_q <= '0;
      for (int i = 0; i < DATA_W; i++) cnt_q[i] <= '0;
    end else begin
      f_q <= f_d;
      for (int i = 0; i < DATA_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign q = f_q;

endmodule
`endif

// File: rtl/jtag_debug_sys_pio_irq.sv
// Avalon-MM input PIO with synchroniser, edge capture (W1C), IRQ mask and level irq.
// Optional input debounce enabled by JTAG_DEBUG_SYS_PIO_DEBOUNCE_EN.
module jtag_debug_sys_pio_irq
  import jtag_debug_sys_pio_pkg::*;
#(
  parameter int unsigned       DATA_W          = 32,
  parameter int unsigned       EDGE_TYPE       = 0,
  parameter logic [DATA_W-1:0] RESET_MASK      = '0,
  parameter int unsigned       DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [DATA_W-1:0] in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  if (DATA_W < 1 || DATA_W > 32 || EDGE_TYPE > 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("jtag_debug_sys_pio_irq: illegal parameter value");
  end

  logic [DATA_W-1:0] s1_q, s1_d;
  logic [DATA_W-1:0] s2_q, s2_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic [DATA_W-1:0] edgecap_q, edgecap_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] f_c;
  logic [DATA_W-1:0] edge_c;
  logic [DATA_W-1:0] clr_c;
  logic              unused_wdata;

  assign unused_wdata = ^writedata;

`ifdef JTAG_DEBUG_SYS_PIO_DEBOUNCE_EN
  jtag_debug_sys_pio_debounce #(
    .DATA_W (DATA_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (s2_q),
    .q       (f_c)
  );
`else
  assign f_c = s2_q;
`endif

  // Next-state: sync chain, edge capture with set-over-clear, mask and read mux.
  always_comb begin
    s1_d   = in_port;
    s2_d   = s1_q;
    prev_d = f_c;
    for (int i = 0; i < DATA_W; i++) edge_c[i] = edge_detect(f_c[i], prev_q[i], EDGE_TYPE);

    clr_c     = (!write_n && address == ADDR_EDGECAP) ? writedata[DATA_W-1:0] : '0;
    edgecap_d = (edgecap_q & ~clr_c) | edge_c;
    mask_d    = (!write_n && address == ADDR_MASK) ? writedata[DATA_W-1:0] : mask_q;

    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d = 32'(f_c);
      ADDR_RSVD:    readdata_d = '0;
      ADDR_MASK:    readdata_d = 32'(mask_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:      readdata_d = '0;
    endcase

    // Same value as |(edgecap_q & mask_q) one edge later, but held in a flop.
    irq_d = |(edgecap_d & mask_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      edgecap_q  <= '0;
      mask_q     <= RESET_MASK;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      edgecap_q  <= edgecap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
